// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - execute-to-control request bundle (jump and hold) for pc_ctrl
//
// Purpose : groups the requests the execute stage raises combinationally toward the
//           program-counter / pipeline-control unit.
// Signals : jump_en   - execute requests a redirect this cycle
//           jump_addr - redirect target, meaningful only while jump_en=1
//           hold_flag - execute requests a pipeline freeze
// Modports: master (execute stage, drives), slave (pc_ctrl, receives)

interface pc_ctrl_if;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        hold_flag;

   modport master (output jump_en, output jump_addr, output hold_flag);
   modport slave  (input  jump_en, input  jump_addr, input  hold_flag);
endinterface

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter and pipeline flush/hold control for the 3-stage core
//
// Purpose : owns the PC feeding the synchronous-read instruction ROM, applies redirects
//           and freezes requested by execute, and squashes the fetch slots that the
//           ROM read latency leaves behind after a redirect.
// Ports   : clk            - system clock, rising edge
//           rst            - asynchronous active-high reset
//           ex_if          - slave side of pc_ctrl_if (jump_en, jump_addr, hold_flag)
//           pc_o           - instruction ROM address
//           inst_addr_o    - pc_o delayed one edge; address of the word on ROM data out
//           if_id_flush_o  - if_id loads a NOP at the next edge
//           id_ex_flush_o  - id_ex loads a NOP at the next edge
//           if_id_hold_o   - if_id keeps its contents
//           id_ex_hold_o   - id_ex keeps its contents
//           misalign_o     - one-cycle pulse after an accepted target with [1:0] != 0
//           redirect_cnt_o - wrapping count of accepted redirects

module pc_ctrl #(
   parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   pc_ctrl_if.slave         ex_if,
   output logic [31:0]      pc_o,
   output logic [31:0]      inst_addr_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             if_id_hold_o,
   output logic             id_ex_hold_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   state_e           ret_q,   ret_d;
   state_e           eff_state;
   logic [2:0]       fcnt_q,  fcnt_d;
   logic [31:0]      pc_q,    pc_d;
   logic [31:0]      inst_q,  inst_d;
   logic             mis_q,   mis_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic             if_id_flush_c, id_ex_flush_c;
   logic             if_id_hold_c,  id_ex_hold_c;

   // Leaving HOLD happens in the same evaluation that sees hold_flag drop, so the
   // unit simply behaves as the state it was frozen in.
   assign eff_state = (state_q == ST_HOLD) ? ret_q : state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
         fcnt_q  <= 3'd0;
         pc_q    <= RESET_ADDR;
         inst_q  <= RESET_ADDR;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         fcnt_q  <= fcnt_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      fcnt_d        = fcnt_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      mis_d         = 1'b0;
      cnt_d         = cnt_q;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      if_id_hold_c  = 1'b0;
      id_ex_hold_c  = 1'b0;

      if (ex_if.hold_flag) begin
         // Freeze everything; a concurrent jump is dropped because id_ex is frozen
         // and execute will present it again once the hold is released.
         if_id_hold_c = 1'b1;
         id_ex_hold_c = 1'b1;
         state_d      = ST_HOLD;
         ret_d        = eff_state;
      end else if (ex_if.jump_en) begin
         // Both younger instructions are on the wrong path.
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
         pc_d          = {ex_if.jump_addr[31:2], 2'b00};
         inst_d        = pc_q;
         fcnt_d        = FLUSH_INIT;
         state_d       = ST_FLUSH;
         ret_d         = ST_RUN;
         cnt_d         = cnt_q + CNT_ONE;
         mis_d         = |ex_if.jump_addr[1:0];
      end else begin
         pc_d   = pc_q + 32'd4;
         inst_d = pc_q;
         ret_d  = ST_RUN;
         if (eff_state == ST_FLUSH) begin
            // ROM data for the slots fetched before/at the redirect is still stale.
            if_id_flush_c = 1'b1;
            fcnt_d        = fcnt_q - 3'd1;
            state_d       = (fcnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
         end else begin
            state_d = ST_RUN;
         end
      end
   end

   // While reset is applied the pipeline controls must be quiet even if execute
   // is still presenting requests.
   assign if_id_flush_o  = if_id_flush_c & ~rst;
   assign id_ex_flush_o  = id_ex_flush_c & ~rst;
   assign if_id_hold_o   = if_id_hold_c  & ~rst;
   assign id_ex_hold_o   = id_ex_hold_c  & ~rst;

   assign pc_o           = pc_q;
   assign inst_addr_o    = inst_q;
   assign misalign_o     = mis_q;
   assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl (default and FLUSH_CYCLES=3/CNT_W=4)

module tb_pc_ctrl;

   logic        clk;
   logic        rst;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        hold_flag;

   int n_cmp = 0;
   int n_err = 0;

   pc_ctrl_if if_a ();
   pc_ctrl_if if_b ();

   assign if_a.jump_en   = jump_en;
   assign if_a.jump_addr = jump_addr;
   assign if_a.hold_flag = hold_flag;
   assign if_b.jump_en   = jump_en;
   assign if_b.jump_addr = jump_addr;
   assign if_b.hold_flag = hold_flag;

   logic [31:0] pc_a, inst_a, cnt_a;
   logic [31:0] pc_b, inst_b;
   logic [3:0]  cnt_b;
   logic        iff_a, idf_a, ifh_a, idh_a, mis_a;
   logic        iff_b, idf_b, ifh_b, idh_b, mis_b;

   pc_ctrl dut_a (
      .clk(clk), .rst(rst), .ex_if(if_a.slave),
      .pc_o(pc_a), .inst_addr_o(inst_a),
      .if_id_flush_o(iff_a), .id_ex_flush_o(idf_a),
      .if_id_hold_o(ifh_a), .id_ex_hold_o(idh_a),
      .misalign_o(mis_a), .redirect_cnt_o(cnt_a)
   );

   pc_ctrl #(.RESET_ADDR(32'h0), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .ex_if(if_b.slave),
      .pc_o(pc_b), .inst_addr_o(inst_b),
      .if_id_flush_o(iff_b), .id_ex_flush_o(idf_b),
      .if_id_hold_o(ifh_b), .id_ex_hold_o(idh_b),
      .misalign_o(mis_b), .redirect_cnt_o(cnt_b)
   );

   // flags packed as {if_id_flush, id_ex_flush, if_id_hold, id_ex_hold, misalign}
   logic [31:0] a_pc [2];
   logic [31:0] a_inst [2];
   logic [31:0] a_cnt [2];
   logic [4:0]  a_flg [2];
   assign a_pc[0]   = pc_a;
   assign a_pc[1]   = pc_b;
   assign a_inst[0] = inst_a;
   assign a_inst[1] = inst_b;
   assign a_cnt[0]  = cnt_a;
   assign a_cnt[1]  = {28'd0, cnt_b};
   assign a_flg[0]  = {iff_a, idf_a, ifh_a, idh_a, mis_a};
   assign a_flg[1]  = {iff_b, idf_b, ifh_b, idh_b, mis_b};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: PC, trailing address, redirect count, pending misalign pulse and
   // the number of stale fetch slots still to squash.
   logic [31:0] m_pc [2];
   logic [31:0] m_inst [2];
   logic [31:0] m_cnt [2];
   logic        m_mis [2];
   int          m_sq [2];
   int          fc_of [2];
   logic [31:0] cmask [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_pc[d]   = 32'h0;
         m_inst[d] = 32'h0;
         m_cnt[d]  = 32'h0;
         m_mis[d]  = 1'b0;
         m_sq[d]   = 0;
      end
   endtask

   task automatic model_check();
      for (int d = 0; d < 2; d++) begin
         logic [4:0] ef;
         if (rst)             ef = 5'b00000;
         else if (hold_flag)  ef = 5'b00110;
         else if (jump_en)    ef = 5'b11000;
         else if (m_sq[d] > 0) ef = 5'b10000;
         else                 ef = 5'b00000;
         ef[0] = m_mis[d];
         chk(d == 0 ? "model_pc_a"   : "model_pc_b",   a_pc[d],   m_pc[d]);
         chk(d == 0 ? "model_inst_a" : "model_inst_b", a_inst[d], m_inst[d]);
         chk(d == 0 ? "model_cnt_a"  : "model_cnt_b",  a_cnt[d],  m_cnt[d]);
         chk(d == 0 ? "model_flg_a"  : "model_flg_b",  {27'd0, a_flg[d]}, {27'd0, ef});
      end
   endtask

   task automatic apply(input logic r, input logic j, input logic [31:0] a, input logic h);
      @(negedge clk);
      rst = r; jump_en = j; jump_addr = a; hold_flag = h;
      if (r) model_reset();
      #1;
      model_check();
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (hold_flag) begin
               m_mis[d] = 1'b0;
            end else begin
               m_inst[d] = m_pc[d];
               if (jump_en) begin
                  m_pc[d]  = jump_addr & 32'hFFFF_FFFC;
                  m_sq[d]  = fc_of[d];
                  m_cnt[d] = (m_cnt[d] + 32'd1) & cmask[d];
                  m_mis[d] = (jump_addr[1:0] != 2'b00);
               end else begin
                  m_pc[d]  = m_pc[d] + 32'd4;
                  m_mis[d] = 1'b0;
                  if (m_sq[d] > 0) m_sq[d]--;
               end
            end
         end
      end
   endtask

   typedef struct {
      logic        r;
      logic        j;
      logic [31:0] a;
      logic        h;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  flg;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl [19];

   initial begin
      rst = 1'b1; jump_en = 1'b0; jump_addr = 32'h0; hold_flag = 1'b0;
      fc_of[0] = 1; fc_of[1] = 3;
      cmask[0] = 32'hFFFF_FFFF; cmask[1] = 32'h0000_000F;
      model_reset();

      tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h00,  32'h00, 5'b00000, 32'd0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h00,  32'h00, 5'b00000, 32'd0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h04,  32'h00, 5'b00000, 32'd0};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h08,  32'h04, 5'b00000, 32'd0};
      tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0C,  32'h08, 5'b00000, 32'd0};
      tbl[5]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h10,  32'h0C, 5'b11000, 32'd0};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h40,  32'h10, 5'b10000, 32'd1};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  32'h40, 5'b00000, 32'd1};
      tbl[8]  = '{1'b0, 1'b1, 32'h90,  1'b1, 32'h48,  32'h44, 5'b00110, 32'd1};
      tbl[9]  = '{1'b0, 1'b1, 32'h90,  1'b1, 32'h48,  32'h44, 5'b00110, 32'd1};
      tbl[10] = '{1'b0, 1'b1, 32'h90,  1'b1, 32'h48,  32'h44, 5'b00110, 32'd1};
      tbl[11] = '{1'b0, 1'b1, 32'h80,  1'b0, 32'h48,  32'h44, 5'b11000, 32'd1};
      tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h80,  32'h48, 5'b10000, 32'd2};
      tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h84,  32'h80, 5'b00000, 32'd2};
      tbl[14] = '{1'b0, 1'b1, 32'h102, 1'b0, 32'h88,  32'h84, 5'b11000, 32'd2};
      tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 32'h88, 5'b10001, 32'd3};
      tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 32'h100, 5'b00000, 32'd3};
      tbl[17] = '{1'b1, 1'b1, 32'h0,   1'b1, 32'h00,  32'h00, 5'b00000, 32'd0};
      tbl[18] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h00,  32'h00, 5'b00000, 32'd0};

      for (int i = 0; i < 19; i++) begin
         apply(tbl[i].r, tbl[i].j, tbl[i].a, tbl[i].h);
         chk($sformatf("vec%0d_pc", i),   pc_a,   tbl[i].pc);
         chk($sformatf("vec%0d_inst", i), inst_a, tbl[i].inst);
         chk($sformatf("vec%0d_flg", i),  {27'd0, a_flg[0]}, {27'd0, tbl[i].flg});
         chk($sformatf("vec%0d_cnt", i),  cnt_a,  tbl[i].cnt);
         finish_cycle();
      end

      // Three-cycle squash with a two-cycle hold in the middle (pc_b starts at 0x4).
      begin
         logic [31:0] s_pc [7];
         logic [4:0]  s_fl [7];
         logic        s_h  [7];
         logic        s_j  [7];
         s_j = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         s_h = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
         s_pc = '{32'h004, 32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C};
         s_fl = '{5'b11000, 5'b10000, 5'b00110, 5'b00110, 5'b10000, 5'b10000, 5'b00000};
         for (int i = 0; i < 7; i++) begin
            apply(1'b0, s_j[i], 32'h200, s_h[i]);
            chk($sformatf("fl3_%0d_pc", i),  pc_b, s_pc[i]);
            chk($sformatf("fl3_%0d_flg", i), {27'd0, a_flg[1]}, {27'd0, s_fl[i]});
            finish_cycle();
         end
      end

      // Asynchronous reset in the middle of a flush window.
      apply(1'b0, 1'b1, 32'h300, 1'b0);
      finish_cycle();
      @(negedge clk);
      jump_en = 1'b0; hold_flag = 1'b0;
      #1;
      chk("pre_rst_flush_b", {31'd0, iff_b}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_pc_a",   pc_a,   32'h0);
      chk("async_rst_pc_b",   pc_b,   32'h0);
      chk("async_rst_inst_b", inst_b, 32'h0);
      chk("async_rst_cnt_b",  {28'd0, cnt_b}, 32'h0);
      chk("async_rst_flg_b",  {27'd0, a_flg[1]}, 32'h0);
      model_reset();
      @(posedge clk);

      // Back-to-back redirects to wrap the 4-bit counter.
      for (int k = 1; k <= 17; k++) begin
         apply(1'b0, 1'b1, 32'h1000 + 32'(k) * 32'h10, 1'b0);
         if (k > 1) chk($sformatf("wrap_cnt_after_%0d", k - 1), {28'd0, cnt_b}, 32'((k - 1) % 16));
         finish_cycle();
      end
      apply(1'b0, 1'b0, 32'h0, 1'b0);
      chk("wrap_cnt_after_17_b", {28'd0, cnt_b}, 32'd1);
      chk("wrap_cnt_after_17_a", cnt_a, 32'd17);
      finish_cycle();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic r, j, h;
         logic [31:0] a;
         r = ($urandom_range(0, 49) == 0);
         j = ($urandom_range(0, 3) == 0);
         h = ($urandom_range(0, 4) == 0);
         a = $urandom;
         apply(r, j, a, h);
         finish_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
